mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter that shares the single data-memory port (the DPI-backed pmem access path) between the instruction fetch unit (IFU) and the load/store unit (LSU). It accepts one transaction at a time through valid/ready handshakes, issues it on the memory port and returns the read data to the requester that owns the transaction. It sits between the IFU/LSU and the memory access block. A watchdog converts a lost memory response into an error response.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles in WAIT before error; 8-bit counter, range 1..255
- sys_clk  in  1  clock; all logic on posedge
- sys_rst  in  1  synchronous, active-high reset
- ifu_req_valid / ifu_req_ready  in / out  1  IFU request handshake (read-only requester)
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid / ifu_resp_ready  out / in  1  IFU response handshake
- ifu_rdata  out  DATA_W  fetched word; ifu_err out 1 timeout flag
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_wen  in  1  1 = write, 0 = read
- lsu_addr  in  ADDR_W; lsu_wdata in DATA_W; lsu_wmask in 4  byte-enable mask
- lsu_resp_valid / lsu_resp_ready  out / in  1  LSU response handshake (writes also respond)
- lsu_rdata  out  DATA_W; lsu_err out 1
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_wen out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_wmask out 4
- mem_resp_valid  in  1  one-cycle response pulse; mem_rdata in DATA_W

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset -> IDLE.
- IDLE: grant selection is combinational. Only the winner's req_ready = 1, and only in IDLE with drop_pending = 0. Both valid -> grant the requester not granted last (last_grant register; reset value = LSU, so IFU wins first). Only one valid -> grant it.
- Handshake (valid & ready) latches owner, addr, wen, wdata and wmask. The IFU transaction forces wen = 0, wmask = 4'b0000. The FSM updates last_grant and moves to ISSUE.
- ISSUE: mem_req_valid = 1 with latched fields held stable. mem_req_ready = 1 -> WAIT, counter cleared.
- WAIT: the counter increments each cycle.
  - mem_resp_valid -> latch mem_rdata (0 for writes), err = 0, go to RESP.
  - counter == TIMEOUT -> rdata = 32'h0, err = 1, drop_pending = 1, go to RESP.
- RESP: the owner's resp_valid = 1, rdata and err held stable. Owner resp_ready = 1 -> IDLE. The other requester's resp_valid stays 0.
- drop_pending: the next mem_resp_valid clears it and the data is discarded. While drop_pending = 1, no grants are made in IDLE. mem_resp_valid in IDLE/ISSUE/RESP with drop_pending = 0 is ignored.
- mem_wmask is passed through unmodified, including non-contiguous masks such as 4'b1001. Splitting across words is the memory block's job.

## Timing
- Reset values:
  - all *_ready = 0 during reset; after reset, req_ready as above
  - all *_resp_valid = 0; mem_req_valid = 0; mem_wen = 0; mem_wmask = 0
  - mem_addr = mem_wdata = 0; rdata = 0; err = 0
  - last_grant = LSU; drop_pending = 0; counter = 0
- Minimum latency from request handshake to resp_valid: 3 cycles, with mem_req_ready = 1 and the response in the cycle after the memory accept.
  - cycle 0: handshake
  - cycle 1: ISSUE, memory accepts
  - cycle 2: WAIT, mem_resp_valid
  - cycle 3: resp_valid
- Back-to-back: a new grant is possible in the cycle after resp_ready is accepted. Throughput is one transaction per 4 cycles at best.
- Requester inputs may change while not handshaking. Latched copies are immune.
- mem_resp_valid and timeout in the same cycle: the response wins, err = 0, no drop.
- Reset asserted mid-transaction (any state): return to IDLE next cycle. The in-flight transaction is abandoned without a response, and drop_pending is cleared.
- Timeout: err response appears TIMEOUT+1 cycles after entering WAIT.

## Test plan
- Single IFU read of addr 0x80000000, memory returns 0x00000413 one cycle after accept -> ifu_resp_valid in cycle 3 with ifu_rdata = 0x00000413, ifu_err = 0, lsu_resp_valid stays 0.
- IFU and LSU both valid from reset -> IFU granted first, LSU second. With both continuously valid, grants alternate IFU, LSU, IFU, LSU across 4 transactions.
- LSU write, addr 0x80001003, wdata 0x12345678, wmask 4'b1001 -> mem_wmask = 4'b1001 and mem_addr = 0x80001003 unmodified. lsu_resp_valid is returned with rdata = 0.
- mem_req_ready held 0 for 5 cycles -> mem_req_valid and all mem_* fields stable for 6 cycles, with no req_ready to either requester meanwhile.
- Memory never responds, TIMEOUT = 4 -> lsu_err = 1, lsu_rdata = 0. The next IFU request is not granted until a late mem_resp_valid arrives. That late data must not appear on any response port.
- lsu_resp_ready held 0 for 3 cycles in RESP, then sys_rst asserted -> all outputs return to reset values next cycle, and a fresh IFU request is granted normally afterward.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IFU, LSU and memory-port handshake bundle around the memory arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ifu_req_valid, ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid, ifu_resp_ready;
  logic [DATA_W-1:0] ifu_rdata;
  logic              ifu_err;
  logic              lsu_req_valid, lsu_req_ready, lsu_wen;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata;
  logic [3:0]        lsu_wmask;
  logic              lsu_resp_valid, lsu_resp_ready;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_err;
  logic              mem_req_valid, mem_req_ready, mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  ifu_req_valid, ifu_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
    output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
  );
  modport master (
    output ifu_req_valid, ifu_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
    input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IFU and LSU, one transaction at a time, with a response watchdog
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic          sys_clk,
  input logic          sys_rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t            r_state, w_next;
  logic              r_owner, r_last, r_wen, r_err, r_drop;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [3:0]        r_wmask;
  logic [7:0]        r_cnt;
  logic              w_open, w_gnt_ifu, w_gnt_lsu, w_gnt, w_timeout, w_resp_done, w_ifu_rv, w_lsu_rv;
  // owner/last encoding: 1 = LSU, 0 = IFU
  assign w_open      = r_state == IDLE && !r_drop && !sys_rst;
  assign w_gnt_ifu   = w_open && bus.ifu_req_valid && (!bus.lsu_req_valid || r_last);
  assign w_gnt_lsu   = w_open && bus.lsu_req_valid && (!bus.ifu_req_valid || !r_last);
  assign w_gnt       = w_gnt_ifu || w_gnt_lsu;
  assign w_timeout   = r_cnt == 8'(TIMEOUT);
  assign w_resp_done = r_owner ? bus.lsu_resp_ready : bus.ifu_resp_ready;
  assign w_ifu_rv    = r_state == RESP && !r_owner;
  assign w_lsu_rv    = r_state == RESP && r_owner;
  assign bus.ifu_req_ready  = w_gnt_ifu;
  assign bus.lsu_req_ready  = w_gnt_lsu;
  assign bus.ifu_resp_valid = w_ifu_rv;
  assign bus.lsu_resp_valid = w_lsu_rv;
  assign bus.ifu_rdata      = w_ifu_rv ? r_rdata : '0;
  assign bus.lsu_rdata      = w_lsu_rv ? r_rdata : '0;
  assign bus.ifu_err        = w_ifu_rv && r_err;
  assign bus.lsu_err        = w_lsu_rv && r_err;
  assign bus.mem_req_valid  = r_state == ISSUE;
  assign bus.mem_wen        = r_wen;
  assign bus.mem_addr       = r_addr;
  assign bus.mem_wdata      = r_wdata;
  assign bus.mem_wmask      = r_wmask;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_gnt ? ISSUE : IDLE;
      ISSUE:   w_next = bus.mem_req_ready ? WAIT : ISSUE;
      WAIT:    w_next = (bus.mem_resp_valid || w_timeout) ? RESP : WAIT;
      default: w_next = w_resp_done ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_wen   <= 1'b0;
      r_err   <= 1'b0;
      r_drop  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_wmask <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_gnt) begin
        r_owner <= w_gnt_lsu;
        r_last  <= w_gnt_lsu;
        r_addr  <= w_gnt_lsu ? bus.lsu_addr : bus.ifu_addr;
        r_wen   <= w_gnt_lsu && bus.lsu_wen;
        r_wdata <= w_gnt_lsu ? bus.lsu_wdata : '0;
        r_wmask <= w_gnt_lsu ? bus.lsu_wmask : 4'b0000;
      end
      r_cnt <= r_state == WAIT ? r_cnt + 8'd1 : '0;
      // a real response beats a simultaneous timeout; a late response after timeout is swallowed
      if (r_state == WAIT && bus.mem_resp_valid) begin
        r_rdata <= r_wen ? '0 : bus.mem_rdata;
        r_err   <= 1'b0;
      end else if (r_state == WAIT && w_timeout) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
        r_drop  <= 1'b1;
      end else if (r_drop && bus.mem_resp_valid) begin
        r_drop  <= 1'b0;
      end
    end
  end
endmodule
